pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage integer/FP pipeline. Drives the 2-bit control of the IF/ID, ID/EX, EX/MEM and MEM/WB LatchN registers and the fetch-stage PC hold/redirect. Resolves four hazards:
- load-use
- multi-cycle EX operations
- taken-branch redirect from EX
- data-cache wait in MEM

---
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline latches and fetch PC.
module pipe_hazard_ctrl #(
    parameter int MULTI_LAT   = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rx,
    input  logic [3:0]       id_ry,
    input  logic             id_use_x,
    input  logic             id_use_y,
    input  logic [3:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_multi,
    input  logic             ex_redirect,
    input  logic             mm_req,
    input  logic             mm_ready,
    output logic [1:0]       ifid_ctr,
    output logic [1:0]       idex_ctr,
    output logic [1:0]       exmm_ctr,
    output logic [1:0]       mmwb_ctr,
    output logic             pc_hold,
    output logic             pc_redirect,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int MW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0] ADV = 2'b00, HOLD = 2'b01, FLSH = 2'b10;
    typedef enum logic [1:0] {RUN, MULTI, MEMW} state_t;
    state_t st_q, st_d, saved_q, saved_d;
    logic [3:0] mc_q, mc_d;
    logic [MW-1:0] mw_q, mw_d;
    logic err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic memw, lu, rel, mul_hold;
    always_comb begin
        memw = mm_req && !mm_ready;
        lu = ex_load && ((id_use_x && id_rx == ex_rd) || (id_use_y && id_ry == ex_rd));
        rel = st_q == MEMW && !memw;
        mul_hold = (st_q == MULTI && mc_q != 4'd0) || (st_q == RUN && ex_multi);
        // Past the first four terms the state is RUN or a finishing MULTI, both of which act as RUN.
        {ifid_ctr, idex_ctr, exmm_ctr, mmwb_ctr, pc_hold, pc_redirect} =
            rst         ? {FLSH, FLSH, FLSH, FLSH, 1'b1, 1'b0} :
            memw        ? {HOLD, HOLD, HOLD, FLSH, 1'b1, 1'b0} :
            rel         ? 10'd0 :
            mul_hold    ? {HOLD, HOLD, FLSH, ADV, 1'b1, 1'b0} :
            ex_redirect ? {FLSH, FLSH, ADV, ADV, 1'b0, 1'b1} :
            lu          ? {HOLD, FLSH, ADV, ADV, 1'b1, 1'b0} : 10'd0;
        st_d = st_q;
        saved_d = saved_q;
        mc_d = mc_q;
        mw_d = mw_q;
        err_d = err_q;
        if (memw) begin
            st_d = MEMW;
            saved_d = st_q == MEMW ? saved_q : st_q;
            mw_d = mw_q == MW'(MEM_TIMEOUT) ? mw_q : mw_q + 1'b1;
            err_d = err_q || mw_d == MW'(MEM_TIMEOUT);
        end else if (rel) begin
            st_d = saved_q;
            mw_d = '0;
        end else if (st_q == MULTI) begin
            st_d = mc_q == 4'd0 ? RUN : MULTI;
            mc_d = mc_q == 4'd0 ? mc_q : mc_q - 1'b1;
        end else if (ex_multi) begin
            st_d = MULTI;
            mc_d = 4'(MULTI_LAT - 2);
        end
        // IF/ID is held in every hold pattern, so it alone flags a stall cycle.
        cnt_d = (ifid_ctr == HOLD && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= RUN;
            saved_q <= RUN;
            mc_q <= '0;
            mw_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            st_q <= st_d;
            saved_q <= saved_d;
            mc_q <= mc_d;
            mw_q <= mw_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
    assign mem_err = err_q;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors queued as expectations, checked by a negedge monitor.
module tb_pipe_hazard_ctrl;
    localparam logic [7:0] ALLA = 8'h00, ALLF = 8'hAA, LU = 8'h60, MUL = 8'h58, RDR = 8'hA0, MWT = 8'h56;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] id_rx = '0, id_ry = '0, ex_rd = '0;
    logic id_use_x = 0, id_use_y = 0, ex_load = 0, ex_multi = 0, ex_redirect = 0, mm_req = 0, mm_ready = 0;
    logic [1:0] ifid_ctr, idex_ctr, exmm_ctr, mmwb_ctr, s_ifid, s_idex, s_exmm, s_mmwb;
    logic pc_hold, pc_redirect, mem_err, s_hold, s_redir, s_err;
    logic [15:0] stall_cnt;
    logic [2:0] s_cnt;
    typedef struct {logic [9:0] ctl; logic me; int st; bit known; int id;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, exp_stall = 0, vec = 0;
    bit known = 0;

    pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .id_rx(id_rx), .id_ry(id_ry), .id_use_x(id_use_x),
        .id_use_y(id_use_y), .ex_rd(ex_rd), .ex_load(ex_load), .ex_multi(ex_multi),
        .ex_redirect(ex_redirect), .mm_req(mm_req), .mm_ready(mm_ready), .ifid_ctr(ifid_ctr),
        .idex_ctr(idex_ctr), .exmm_ctr(exmm_ctr), .mmwb_ctr(mmwb_ctr), .pc_hold(pc_hold),
        .pc_redirect(pc_redirect), .mem_err(mem_err), .stall_cnt(stall_cnt));

    pipe_hazard_ctrl #(.CNT_W(3)) u_sat (.clk(clk), .rst(rst), .id_rx(id_rx), .id_ry(id_ry),
        .id_use_x(id_use_x), .id_use_y(id_use_y), .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_multi(ex_multi), .ex_redirect(ex_redirect), .mm_req(mm_req), .mm_ready(mm_ready),
        .ifid_ctr(s_ifid), .idex_ctr(s_idex), .exmm_ctr(s_exmm), .mmwb_ctr(s_mmwb),
        .pc_hold(s_hold), .pc_redirect(s_redir), .mem_err(s_err), .stall_cnt(s_cnt));

    always #5 clk = ~clk;

    task automatic step(input logic r, ld, ux, uy, input logic [3:0] rx, ry, rd,
                        input logic mul, rdir, req, rdy, input logic [7:0] ctr, input logic ph, pr, me);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_load = ld; id_use_x = ux; id_use_y = uy; id_rx = rx; id_ry = ry; ex_rd = rd;
        ex_multi = mul; ex_redirect = rdir; mm_req = req; mm_ready = rdy;
        e.ctl = {ctr, ph, pr};
        e.me = me;
        e.st = exp_stall;
        e.known = known;
        e.id = vec;
        vec++;
        q.push_back(e);
        if (r) begin
            exp_stall = 0;
            known = 1;
        end else if (ctr[7:6] == 2'b01) exp_stall++;
    endtask

    task automatic idle(input logic [7:0] ctr, input logic ph, me);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctr, ph, 0, me);
    endtask

    task automatic memwait(input logic rdy, input logic [7:0] ctr, input logic ph, me);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rdy, ctr, ph, 0, me);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        int sat;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({ifid_ctr, idex_ctr, exmm_ctr, mmwb_ctr, pc_hold, pc_redirect} !== e.ctl) begin
                fails++;
                $display("FAIL ctl vec %0d: got %b want %b", e.id,
                         {ifid_ctr, idex_ctr, exmm_ctr, mmwb_ctr, pc_hold, pc_redirect}, e.ctl);
            end
            if (e.known) begin
                sat = e.st > 7 ? 7 : e.st;
                tests += 3;
                if (mem_err !== e.me) begin
                    fails++;
                    $display("FAIL mem_err vec %0d: got %b want %b", e.id, mem_err, e.me);
                end
                if (stall_cnt !== 16'(e.st)) begin
                    fails++;
                    $display("FAIL stall_cnt vec %0d: got %0d want %0d", e.id, stall_cnt, e.st);
                end
                if (s_cnt !== 3'(sat)) begin
                    fails++;
                    $display("FAIL stall_sat vec %0d: got %0d want %0d", e.id, s_cnt, sat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALLF, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALLF, 1, 0, 0);
        idle(ALLA, 0, 0);
        step(0, 1, 1, 0, 5, 0, 5, 0, 0, 0, 0, LU, 1, 0, 0);
        idle(ALLA, 0, 0);
        step(0, 1, 0, 0, 5, 0, 5, 0, 0, 0, 0, ALLA, 0, 0, 0);
        step(0, 1, 0, 1, 0, 7, 7, 0, 0, 0, 0, LU, 1, 0, 0);
        idle(ALLA, 0, 0);
        step(0, 1, 1, 0, 3, 0, 5, 0, 0, 0, 0, ALLA, 0, 0, 0);
        step(0, 0, 1, 0, 5, 0, 5, 0, 0, 0, 0, ALLA, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MUL, 1, 0, 0);
        idle(MUL, 1, 0);
        idle(MUL, 1, 0);
        idle(ALLA, 0, 0);
        step(0, 1, 1, 0, 5, 0, 5, 0, 1, 0, 0, RDR, 0, 1, 0);
        idle(ALLA, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MUL, 1, 0, 0);
        repeat (5) memwait(0, MWT, 1, 0);
        memwait(1, ALLA, 0, 0);
        idle(MUL, 1, 0);
        idle(MUL, 1, 0);
        idle(ALLA, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MUL, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MUL, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MUL, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RDR, 0, 1, 0);
        idle(ALLA, 0, 0);
        for (int i = 0; i < 64; i++) memwait(0, MWT, 1, 0);
        memwait(1, ALLA, 0, 1);
        idle(ALLA, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MUL, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALLF, 1, 0, 1);
        idle(ALLA, 0, 0);
        idle(ALLA, 0, 0);
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
